systolic_gemm_ctrl: RTL and testbench

- Parametrised N×N output-stationary systolic matrix-multiply block with its own sequencer, input buffer and result buffer.
- Host fills the input buffer, pulses start, and the internal FSM streams K operand words through the array, then writes N result rows to the result buffer.
- Generalises the fixed 4×4, host-sequenced array top to any N, operand/accumulator width, buffer depth and signed/unsigned mode.
- Sits between the host/DMA bus and downstream result consumers.

---
 rtl/systolic_gemm_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_systolic_gemm_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_gemm_ctrl.sv
// N x N output-stationary systolic GEMM with its own sequencer,
// operand input buffer and result row buffer.
module systolic_gemm_ctrl #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int AW        = 24,
  parameter int IN_DEPTH  = 2048,
  parameter int OUT_DEPTH = 256,
  parameter int SIGNED    = 1,
  localparam int IAW = $clog2(IN_DEPTH),
  localparam int OAW = $clog2(OUT_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IAW-1:0]    k_len,
  input  logic [IAW-1:0]    in_base,
  input  logic [OAW-1:0]    out_base,
  input  logic              in_wr_en,
  input  logic [IAW-1:0]    in_addr,
  input  logic [2*N*DW-1:0] in_din,
  input  logic              out_rd_en,
  input  logic [OAW-1:0]    out_addr,
  output logic [N*AW-1:0]   out_dout,
  output logic              out_dvalid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = (IAW > $clog2(2*N)) ? IAW + 1 : $clog2(2*N) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IAW-1:0]  k_len_q, k_len_d;
  logic [IAW-1:0]  in_base_q, in_base_d;
  logic [OAW-1:0]  out_base_q, out_base_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            vld_q, vld_d;
  logic            dval_q, dval_d;
  logic [N*AW-1:0] dout_q;

  logic [2*N*DW-1:0] in_mem [IN_DEPTH];
  logic [N*AW-1:0]   out_mem [OUT_DEPTH];
  logic [2*N*DW-1:0] rd_q;
  logic [IAW-1:0]    rd_addr;
  logic [OAW-1:0]    wr_addr;
  logic [IAW:0]      rsum;
  logic [OAW:0]      osum;
  logic [N*AW-1:0]   row;
  logic              clr;

  logic [DW-1:0] fa [N];
  logic [DW-1:0] fb [N];
  logic [DW-1:0] sa [N];
  logic [DW-1:0] sb [N];

  logic [N-1:0][N-1:0][DW-1:0] a_q, a_d, b_q, b_d;
  logic [N-1:0][N-1:0][AW-1:0] acc_q, acc_d;

  function automatic logic [AW-1:0] ext(input logic [DW-1:0] x);
    if (SIGNED != 0) return {{(AW-DW){x[DW-1]}}, x};
    return {{(AW-DW){1'b0}}, x};
  endfunction

  assign clr = (state_q == S_CLEAR);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_len_d    = k_len_q;
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    err_d      = err_q;
    vld_d      = (state_q == S_FEED);
    dval_d     = out_rd_en;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CLEAR;
          cnt_d      = '0;
          k_len_d    = k_len;
          in_base_d  = in_base;
          out_base_d = out_base;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = (k_len_q == '0) ? S_FLUSH : S_FEED;
      end
      S_FEED: begin
        if (cnt_q == CW'(k_len_q) - CW'(1)) begin
          cnt_d   = '0;
          state_d = S_FLUSH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FLUSH: begin
        if (cnt_q == CW'(2*N-1)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(N-1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_q == S_IDLE && start) err_d = 1'b0;
    else if (in_wr_en && busy_q)    err_d = 1'b1;
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      k_len_q    <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      vld_q      <= 1'b0;
      dval_q     <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_len_q    <= k_len_d;
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      vld_q      <= vld_d;
      dval_q     <= dval_d;
      if (out_rd_en) dout_q <= out_mem[out_addr];
    end
  end

  // Modular address arithmetic so non-power-of-two depths wrap too
  always_comb begin
    rsum = {1'b0, in_base_q} + {1'b0, IAW'(cnt_q)};
    if (rsum >= (IAW+1)'(IN_DEPTH)) rsum = rsum - (IAW+1)'(IN_DEPTH);
    rd_addr = rsum[IAW-1:0];
    osum = {1'b0, out_base_q} + {1'b0, OAW'(cnt_q)};
    if (osum >= (OAW+1)'(OUT_DEPTH)) osum = osum - (OAW+1)'(OUT_DEPTH);
    wr_addr = osum[OAW-1:0];
  end

  always_ff @(posedge clk) begin
    if (in_wr_en && !busy_q) in_mem[in_addr] <= in_din;
    if (state_q == S_FEED) rd_q <= in_mem[rd_addr];
    if (state_q == S_DRAIN) out_mem[wr_addr] <= row;
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      fa[i] = vld_q ? rd_q[i*DW +: DW] : '0;
      fb[i] = vld_q ? rd_q[(N+i)*DW +: DW] : '0;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_d0
      assign sa[i] = fa[i];
      assign sb[i] = fb[i];
    end else begin : g_dn
      logic [DW-1:0] ca_q [i];
      logic [DW-1:0] cb_q [i];
      always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
          for (int d = 0; d < i; d++) begin
            ca_q[d] <= '0;
            cb_q[d] <= '0;
          end
        end else begin
          ca_q[0] <= fa[i];
          cb_q[0] <= fb[i];
          for (int d = 1; d < i; d++) begin
            ca_q[d] <= ca_q[d-1];
            cb_q[d] <= cb_q[d-1];
          end
        end
      end
      assign sa[i] = ca_q[i-1];
      assign sb[i] = cb_q[i-1];
    end
  end

  // Each PE registers its operands, then accumulates on the next edge
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (clr) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        a_d[i][0] = sa[i];
        b_d[0][i] = sb[i];
        for (int j = 1; j < N; j++) begin
          a_d[i][j] = a_q[i][j-1];
          b_d[j][i] = b_q[j-1][i];
        end
        for (int j = 0; j < N; j++)
          acc_d[i][j] = acc_q[i][j] + ext(a_q[i][j]) * ext(b_q[i][j]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  always_comb begin
    row = '0;
    for (int r = 0; r < N; r++)
      if (cnt_q == CW'(r))
        for (int j = 0; j < N; j++) row[j*AW +: AW] = acc_q[r][j];
  end

  assign out_dout   = dout_q;
  assign out_dvalid = dval_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_systolic_gemm_ctrl.sv
// Scoreboard bench: signed AW=24 and unsigned AW=16 instances
// share stimulus; expected rows come from a reference GEMM model.
module tb_systolic_gemm_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] k_len;
  logic [10:0] in_base;
  logic [7:0]  out_base;
  logic        in_wr_en;
  logic [10:0] in_addr;
  logic [63:0] in_din;
  logic        out_rd_en;
  logic [7:0]  out_addr;
  logic [95:0] out_dout;
  logic        out_dvalid, busy, done, err;
  logic [63:0] out_dout_u;
  logic        out_dvalid_u, busy_u, done_u, err_u;

  int vec = 0;
  int errs = 0;

  logic [63:0] tbmem [2048];
  logic [95:0] exp_q [$];
  logic [63:0] expu_q [$];

  always #5 clk = ~clk;

  systolic_gemm_ctrl #(.N(4), .DW(8), .AW(24), .SIGNED(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_base(in_base), .out_base(out_base),
    .in_wr_en(in_wr_en), .in_addr(in_addr), .in_din(in_din),
    .out_rd_en(out_rd_en), .out_addr(out_addr),
    .out_dout(out_dout), .out_dvalid(out_dvalid),
    .busy(busy), .done(done), .err(err)
  );

  systolic_gemm_ctrl #(.N(4), .DW(8), .AW(16), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_base(in_base), .out_base(out_base),
    .in_wr_en(in_wr_en), .in_addr(in_addr), .in_din(in_din),
    .out_rd_en(out_rd_en), .out_addr(out_addr),
    .out_dout(out_dout_u), .out_dvalid(out_dvalid_u),
    .busy(busy_u), .done(done_u), .err(err_u)
  );

  function automatic logic [95:0] exp_row(int r, int k, int ib,
                                          bit sgn, int aw);
    logic [95:0] res;
    logic [63:0] w;
    longint s, a, b, mask;
    res  = '0;
    mask = (longint'(1) << aw) - 1;
    for (int j = 0; j < 4; j++) begin
      s = 0;
      for (int kk = 0; kk < k; kk++) begin
        w = tbmem[(ib + kk) % 2048];
        if (sgn) begin
          a = longint'($signed(w[r*8 +: 8]));
          b = longint'($signed(w[(4+j)*8 +: 8]));
        end else begin
          a = longint'(w[r*8 +: 8]);
          b = longint'(w[(4+j)*8 +: 8]);
        end
        s = s + a * b;
      end
      res = res | (96'(s & mask) << (j * aw));
    end
    return res;
  endfunction

  task automatic write_word(int a, logic [63:0] d);
    in_wr_en = 1'b1;
    in_addr  = 11'(a);
    in_din   = d;
    @(negedge clk);
    in_wr_en = 1'b0;
    tbmem[a] = d;
  endtask

  task automatic start_job(int k, int ib, int ob, bit push);
    logic [95:0] e;
    if (push) begin
      for (int r = 0; r < 4; r++) begin
        exp_q.push_back(exp_row(r, k, ib, 1'b1, 24));
        e = exp_row(r, k, ib, 1'b0, 16);
        expu_q.push_back(e[63:0]);
      end
    end
    k_len    = 11'(k);
    in_base  = 11'(ib);
    out_base = 8'(ob);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(string nm, int lat, int c0);
    int cyc = c0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    vec++;
    if (cyc !== lat) begin
      errs++;
      $display("FAIL %s latency: got %0d want %0d", nm, cyc, lat);
    end
    vec++;
    if (busy !== 1'b0 || done_u !== 1'b1) begin
      errs++;
      $display("FAIL %s done: busy=%b done_u=%b want 0 1", nm, busy, done_u);
    end
  endtask

  task automatic read_rows(string nm, int ob);
    logic [95:0] e;
    logic [63:0] eu;
    for (int r = 0; r < 4; r++) begin
      out_rd_en = 1'b1;
      out_addr  = 8'((ob + r) % 256);
      @(negedge clk);
      out_rd_en = 1'b0;
      e  = exp_q.pop_front();
      eu = expu_q.pop_front();
      vec++;
      if (out_dout !== e || out_dvalid !== 1'b1) begin
        errs++;
        $display("FAIL %s row%0d: got %h v=%b want %h", nm, r,
                 out_dout, out_dvalid, e);
      end
      vec++;
      if (out_dout_u !== eu) begin
        errs++;
        $display("FAIL %s urow%0d: got %h want %h", nm, r, out_dout_u, eu);
      end
    end
    @(negedge clk);
    vec++;
    if (out_dvalid !== 1'b0 || out_dout !== e) begin
      errs++;
      $display("FAIL %s hold: got %h v=%b want %h v=0", nm,
               out_dout, out_dvalid, e);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0; k_len = '0; in_base = '0; out_base = '0;
    in_wr_en = 1'b0; in_addr = '0; in_din = '0;
    out_rd_en = 1'b0; out_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vec++;
    if ({busy, done, err, out_dvalid} !== 4'b0 || out_dout !== '0) begin
      errs++;
      $display("FAIL reset: got b%b d%b e%b v%b dout=%h want all 0",
               busy, done, err, out_dvalid, out_dout);
    end
  endtask

  task automatic test_identity;
    logic [63:0] w;
    for (int k = 0; k < 4; k++) begin
      w = '0;
      w[k*8 +: 8] = 8'd1;
      for (int j = 0; j < 4; j++) w[(4+j)*8 +: 8] = 8'((j+1)*(k+1));
      write_word(k, w);
    end
    start_job(4, 0, 0, 1'b1);
    vec++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL ident busy: got %b want 1", busy);
    end
    wait_done("ident", 17, 0);
    @(negedge clk);
    vec++;
    if (done !== 1'b0) begin
      errs++;
      $display("FAIL ident pulse: done got %b want 0", done);
    end
    read_rows("ident", 0);
  endtask

  task automatic test_neg;
    for (int k = 0; k < 3; k++) write_word(8 + k, {8{8'h80}});
    start_job(3, 8, 4, 1'b1);
    wait_done("neg", 1 + 3 + 12, 0);
    read_rows("neg", 4);
  endtask

  task automatic test_unsigned;
    for (int k = 0; k < 2; k++) write_word(16 + k, {8{8'hFF}});
    start_job(2, 16, 8, 1'b1);
    wait_done("uns", 1 + 2 + 12, 0);
    read_rows("uns", 8);
  endtask

  task automatic test_wrap_err;
    for (int k = 0; k < 4; k++)
      write_word((2046 + k) % 2048, 64'($urandom) << 32 | 64'($urandom));
    start_job(4, 2046, 20, 1'b1);
    repeat (2) @(negedge clk);
    start    = 1'b1;
    k_len    = 11'd1;
    in_base  = 11'd5;
    out_base = 8'd99;
    in_wr_en = 1'b1;
    in_addr  = 11'd1;
    in_din   = '1;
    @(negedge clk);
    start    = 1'b0;
    in_wr_en = 1'b0;
    vec++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      errs++;
      $display("FAIL err set: got err=%b busy=%b want 1 1", err, busy);
    end
    wait_done("wrap", 17, 3);
    read_rows("wrap", 20);
  endtask

  task automatic test_k0_outwrap;
    start_job(0, 0, 254, 1'b1);
    vec++;
    if (err !== 1'b0) begin
      errs++;
      $display("FAIL err clear: got %b want 0", err);
    end
    wait_done("k0", 13, 0);
    read_rows("k0", 254);
  endtask

  task automatic test_rst_mid;
    int seen = 0;
    start_job(4, 0, 40, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL rst mid: busy=%b done=%b want 0 0", busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen++;
    end
    vec++;
    if (seen !== 0) begin
      errs++;
      $display("FAIL rst nodone: got %0d pulses want 0", seen);
    end
    start_job(4, 0, 40, 1'b1);
    wait_done("rerun", 17, 0);
    read_rows("rerun", 40);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_neg();
    test_unsigned();
    test_wrap_err();
    test_k0_outwrap();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
